// File: rtl/timer_pkg.sv
// Shared definitions for the programmable down-counting timer peripheral:
// FSM state encoding, register offsets, CTRL bit positions and mode codes.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

    // Register offsets (byte address bits [3:2])
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // Mode codes; 2'b1x behaves like one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Only the exact reload code selects auto-reload; everything else is one-shot.
    function automatic logic is_reload(input logic [1:0] mode);
        return (mode == MODE_RELOAD);
    endfunction

endpackage

// File: rtl/timer_irq_dev.sv
// Programmable down-counting timer on the CPU system bridge. CTRL/PRESET/COUNT
// registers, a four-state counting FSM and a level interrupt to the CPU.
// The FSM sees an EN bit being written on the same edge, so a CTRL write that
// sets EN moves IDLE->LOAD on that very edge.
module timer_irq_dev
    import timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             irq
);

    localparam logic [WIDTH-1:0] COUNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] COUNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    timer_state_e     state_r;
    timer_state_e     state_nxt_s;
    logic [3:0]       ctrl_r;
    logic [3:0]       ctrl_nxt_s;
    logic [WIDTH-1:0] preset_r;
    logic [WIDTH-1:0] preset_nxt_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             pend_r;
    logic             pend_nxt_s;

    logic             ctrl_wr_s;
    logic             preset_wr_s;
    logic             en_eff_s;
    logic             pend_set_s;
    logic             pend_clr_s;
    logic             en_clr_s;

    // Next-state logic: FSM transitions, counter update, register writes and pend.
    always_comb begin
        ctrl_wr_s    = we && (addr == ADDR_CTRL);
        preset_wr_s  = we && (addr == ADDR_PRESET);
        en_eff_s     = ctrl_wr_s ? wdata[CTRL_EN] : ctrl_r[CTRL_EN];
        state_nxt_s  = state_r;
        count_nxt_s  = count_r;
        pend_set_s   = 1'b0;
        pend_clr_s   = 1'b0;
        en_clr_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (en_eff_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                count_nxt_s = preset_r;
                if (en_eff_s) begin
                    state_nxt_s = ST_CNT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CNT: begin
                if (!en_eff_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (count_r > COUNT_ONE) begin
                    count_nxt_s = count_r - COUNT_ONE;
                    state_nxt_s = ST_CNT;
                end else begin
                    // PRESET 0 and 1 both land here; never wrap below zero
                    count_nxt_s = COUNT_ZERO;
                    state_nxt_s = ST_INT;
                    pend_set_s  = 1'b1;
                end
            end
            ST_INT: begin
                if (is_reload(ctrl_r[CTRL_MODE_HI:CTRL_MODE_LO])) begin
                    state_nxt_s = ST_LOAD;
                    pend_clr_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                    en_clr_s    = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // A bus write to CTRL takes priority over the one-shot EN clear.
        if (ctrl_wr_s) begin
            ctrl_nxt_s = wdata[3:0];
        end else if (en_clr_s) begin
            ctrl_nxt_s = ctrl_r & 4'b1110;
        end else begin
            ctrl_nxt_s = ctrl_r;
        end

        if (preset_wr_s) begin
            preset_nxt_s = wdata;
        end else begin
            preset_nxt_s = preset_r;
        end

        // Any CTRL write acknowledges the interrupt, even against a new set.
        if (ctrl_wr_s) begin
            pend_nxt_s = 1'b0;
        end else if (pend_set_s) begin
            pend_nxt_s = 1'b1;
        end else if (pend_clr_s) begin
            pend_nxt_s = 1'b0;
        end else begin
            pend_nxt_s = pend_r;
        end
    end

    // State and register file, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            ctrl_r   <= 4'd0;
            preset_r <= COUNT_ZERO;
            count_r  <= COUNT_ZERO;
            pend_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            ctrl_r   <= ctrl_nxt_s;
            preset_r <= preset_nxt_s;
            count_r  <= count_nxt_s;
            pend_r   <= pend_nxt_s;
        end
    end

    // Read mux, combinational from addr with no side effects.
    always_comb begin
        case (addr)
            ADDR_CTRL:   rdata = {{(WIDTH-4){1'b0}}, ctrl_r};
            ADDR_PRESET: rdata = preset_r;
            ADDR_COUNT:  rdata = count_r;
            default:     rdata = COUNT_ZERO;
        endcase
    end

    // One-shot holds irq until acknowledged; auto-reload gives a one-cycle pulse in INT.
    assign irq = pend_r & ctrl_r[CTRL_IM] &
                 ((state_r == ST_INT) | !is_reload(ctrl_r[CTRL_MODE_HI:CTRL_MODE_LO]));

endmodule

// File: tb/tb_timer_irq_dev.sv
// Directed self-checking bench for timer_irq_dev.
module tb_timer_irq_dev;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    timer_irq_dev #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    logic [31:0] v;
    int pulses;
    int first_pulse;
    int last_pulse;
    int gap_bad;

    initial begin
        reset = 1'b0;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = 32'd0;

        // 1: reset
        repeat (3) @(posedge clk);
        #1;
        rd(2'd0, v); check("rst_ctrl", v, 32'd0);
        rd(2'd1, v); check("rst_preset", v, 32'd0);
        rd(2'd2, v); check("rst_count", v, 32'd0);
        chk_irq("rst_irq", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        tick(); tick();
        rd(2'd2, v); check("idle_count", v, 32'd0);
        wr(2'd0, 32'hFFFF_FFF0);
        rd(2'd0, v); check("ctrl_upper_ignored", v, 32'd0);
        wr(2'd3, 32'h1234_5678);
        rd(2'd3, v); check("addr3_reads0", v, 32'd0);

        // 2: one-shot, PRESET=5
        wr(2'd1, 32'd5);
        rd(2'd1, v); check("preset_rd", v, 32'd5);
        wr(2'd0, 32'h9);                        // E0
        rd(2'd2, v); check("os_load_count", v, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            rd(2'd2, v); check("os_count", v, 32'(6 - i));
            chk_irq("os_irq_low", 1'b0);
        end
        tick();                                 // E6
        rd(2'd2, v); check("os_count_zero", v, 32'd0);
        chk_irq("os_irq_set", 1'b1);
        tick();
        chk_irq("os_irq_held", 1'b1);
        rd(2'd0, v); check("os_en_cleared", v, 32'h8);
        tick();
        chk_irq("os_irq_held2", 1'b1);
        rd(2'd2, v); check("os_count_stays0", v, 32'd0);
        wr(2'd0, 32'd0);
        chk_irq("os_irq_ack", 1'b0);

        // 3: auto-reload, PRESET=3
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);                        // E0
        pulses = 0; first_pulse = -1; last_pulse = -1; gap_bad = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (irq) begin
                if (first_pulse < 0) first_pulse = t;
                else if (t - last_pulse != 5) gap_bad++;
                last_pulse = t;
                pulses++;
            end
        end
        check("ar_pulses", 32'(pulses), 32'd4);
        check("ar_first", 32'(first_pulse), 32'd4);
        check("ar_gap", 32'(gap_bad), 32'd0);
        rd(2'd0, v); check("ar_en_kept", v, 32'hB);
        wr(2'd0, 32'd0);
        tick(); tick();
        chk_irq("ar_stop_irq", 1'b0);

        // 4: masked, PRESET=2
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);                        // E0
        for (int t = 1; t <= 4; t++) begin
            tick();
            chk_irq("mask_irq", 1'b0);
        end
        rd(2'd2, v); check("mask_count0", v, 32'd0);
        wr(2'd0, 32'h8);
        chk_irq("mask_unmask_irq", 1'b0);
        tick();
        chk_irq("mask_unmask_irq2", 1'b0);

        // 5: mid-operation disable, COUNT write, async reset
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);                        // E0
        repeat (5) tick();                      // E5
        rd(2'd2, v); check("mid_count6", v, 32'd6);
        wr(2'd0, 32'h8);                        // disable
        rd(2'd2, v); check("mid_frozen", v, 32'd6);
        tick(); tick();
        rd(2'd2, v); check("mid_frozen2", v, 32'd6);
        chk_irq("mid_no_irq", 1'b0);
        wr(2'd2, 32'd99);
        rd(2'd2, v); check("mid_count_wr_ign", v, 32'd6);
        wr(2'd0, 32'h9);                        // re-enable, reloads 10
        tick();
        rd(2'd2, v); check("mid_reload", v, 32'd10);
        repeat (6) tick();
        rd(2'd2, v); check("mid_count4", v, 32'd4);
        reset = 1'b0;
        #1;
        rd(2'd0, v); check("arst_ctrl", v, 32'd0);
        rd(2'd1, v); check("arst_preset", v, 32'd0);
        rd(2'd2, v); check("arst_count", v, 32'd0);
        chk_irq("arst_irq", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        tick(); tick(); tick();
        rd(2'd2, v); check("arst_idle_count", v, 32'd0);
        rd(2'd0, v); check("arst_idle_ctrl", v, 32'd0);

        // 6: PRESET 0 and 1 reach irq after E0+2
        for (int p = 0; p <= 1; p++) begin
            wr(2'd1, 32'(p));
            wr(2'd0, 32'h9);                    // E0
            tick();
            chk_irq("edge_irq_e1", 1'b0);
            tick();
            chk_irq("edge_irq_e2", 1'b1);
            wr(2'd0, 32'd0);
            chk_irq("edge_ack", 1'b0);
            tick();
        end
        wr(2'd1, 32'hFFFF_FFFF);
        wr(2'd0, 32'h9);
        tick();
        rd(2'd2, v); check("max_load", v, 32'hFFFF_FFFF);
        tick();
        rd(2'd2, v); check("max_dec", v, 32'hFFFF_FFFE);
        wr(2'd0, 32'd0);
        rd(2'd2, v); check("max_frozen", v, 32'hFFFF_FFFE);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

endmodule
